// File: rtl/soc_bus_pkg.sv
// soc_bus shared definitions: I/O page decode, register map, status bits, serializer states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package soc_bus_pkg;

  // Address bit that separates RAM (0) from the I/O page (1)
  localparam int IO_SEL_BIT = 22;

  // I/O register select, taken from mem_addr[4:2]
  localparam logic [2:0] REG_LEDS        = 3'd0;
  localparam logic [2:0] REG_UART_DATA   = 3'd1;
  localparam logic [2:0] REG_UART_STATUS = 3'd2;

  // UART_STATUS bit positions
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  // Serializer frame states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/soc_bus_uart_tx.sv
// Transmit-only UART: TX queue (SOC_BUS_UART_FIFO_EN = FIFO, otherwise one holding register) + 8N1 serializer.
// Latency: push at edge N -> pop at N+1 -> uart_tx low from N+2; frame is 10*BAUD_DIV cycles.
// Backpressure: none; a push into a full queue is dropped and sets sticky overflow unless a pop happens that cycle.
module soc_bus_uart_tx
  import soc_bus_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_vld,
  input  logic [7:0] push_dat,
  input  logic       ovf_clr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf,
  output logic       uart_tx
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    head_dat;
  logic          pop;
  logic          push_acc;

  // A pop in the same cycle frees a slot, so a push to a full queue still lands
  assign push_acc = push_vld && (!full || pop);
  assign pop      = !empty && (state == TX_IDLE || (state == TX_STOP && baud_cnt == '0));
  assign busy     = (state != TX_IDLE);

`ifdef SOC_BUS_UART_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;

  assign full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign empty    = (fifo_cnt == '0);
  assign head_dat = fifo_mem[rd_ptr];

  // Queue storage, written at the wrap-around write pointer
  always_ff @(posedge clk) begin
    if (push_acc) fifo_mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  logic        hold_vld;
  logic [7:0]  hold_dat;
  logic [31:0] unused_depth;

  assign unused_depth = FIFO_DEPTH;
  assign full         = hold_vld;
  assign empty        = !hold_vld;
  assign head_dat     = hold_dat;

  // Single-entry holding register; a simultaneous push and pop refills it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (push_acc) begin
      hold_vld <= 1'b1;
      hold_dat <= push_dat;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  // Sticky overflow: set by a dropped push, cleared by a status write
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf <= 1'b0;
    else if (push_vld && !push_acc) ovf <= 1'b1;
    else if (ovf_clr)               ovf <= 1'b0;
  end

  // Serializer FSM; uart_tx is registered from the current state, so it trails state by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        TX_START: uart_tx <= 1'b0;
        TX_DATA:  uart_tx <= shreg[bit_idx];
        default:  uart_tx <= 1'b1;
      endcase
      case (state)
        TX_IDLE: begin
          if (pop) begin
            shreg    <= head_dat;
            baud_cnt <= BAUD_LAST;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LAST;
            bit_idx  <= '0;
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        TX_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LAST;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= TX_STOP;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        TX_STOP: begin
          if (baud_cnt == '0) begin
            if (pop) begin
              shreg    <= head_dat;
              baud_cnt <= BAUD_LAST;
              state    <= TX_START;
            end else begin
              state    <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/soc_bus.sv
// Core memory bus: decodes requests to byte-masked RAM or an I/O page (LEDs, UART; SOC_BUS_UART_FIFO_EN adds a TX FIFO).
// Latency: reads return one cycle after mem_rstrb; writes land on the edge where mem_wmask is nonzero.
// Backpressure: none (zero wait states); UART pushes to a full queue are dropped and flagged.
module soc_bus
  import soc_bus_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter     INIT_FILE  = "",
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              io_sel;
  logic [2:0]        reg_sel;
  logic              wr_any;
  logic              ram_we;
  logic [31:0]       ram_rd_dat;
  logic [31:0]       io_rd_dat;
  logic [31:0]       io_rd_q;
  logic              rd_vld;
  logic              rd_io;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_busy;
  logic              tx_ovf;
  logic              push_vld;
  logic              ovf_clr;
  logic [31:0]       unused_addr;

  // Upper RAM index bits are deliberately ignored so the RAM aliases across the space
  assign unused_addr = mem_addr;
  assign ram_idx     = mem_addr[RAM_AW+1:2];
  assign io_sel      = mem_addr[IO_SEL_BIT];
  assign reg_sel     = mem_addr[4:2];
  assign wr_any      = |mem_wmask;
  assign ram_we      = !io_sel && wr_any;
  assign push_vld    = io_sel && wr_any && (reg_sel == REG_UART_DATA);
  assign ovf_clr     = io_sel && wr_any && (reg_sel == REG_UART_STATUS);

  // Byte-lane RAM write
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Synchronous RAM read port, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (mem_rstrb) ram_rd_dat <= ram[ram_idx];
  end

  // I/O read mux; status shows the state left by the previous edge
  always_comb begin
    io_rd_dat = '0;
    case (reg_sel)
      REG_LEDS: io_rd_dat[7:0] = leds;
      REG_UART_STATUS: begin
        io_rd_dat[ST_FULL]  = tx_full;
        io_rd_dat[ST_EMPTY] = tx_empty;
        io_rd_dat[ST_BUSY]  = tx_busy;
        io_rd_dat[ST_OVF]   = tx_ovf;
      end
      default: io_rd_dat = '0;
    endcase
  end

  // Read-side registers; rd_vld keeps mem_rdata at 0 from reset until the first read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_io   <= 1'b0;
      io_rd_q <= '0;
    end else if (mem_rstrb) begin
      rd_vld  <= 1'b1;
      rd_io   <= io_sel;
      io_rd_q <= io_rd_dat;
    end
  end

  assign mem_rdata = !rd_vld ? '0 : (rd_io ? io_rd_q : ram_rd_dat);

  // LED register, low byte lane only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 leds <= '0;
    else if (io_sel && reg_sel == REG_LEDS && mem_wmask[0]) leds <= mem_wdata[7:0];
  end

  soc_bus_uart_tx #(
    .BAUD_DIV   (BAUD_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (mem_wdata[7:0]),
    .ovf_clr  (ovf_clr),
    .full     (tx_full),
    .empty    (tx_empty),
    .busy     (tx_busy),
    .ovf      (tx_ovf),
    .uart_tx  (uart_tx)
  );

endmodule
